// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory access path.
// Contents: RISC-V load/store funct3 encodings and the state encoding of the
// mem_access_unit sequencer (exposed on its state_o debug port).
package riscv_pkg;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Wishbone-style classic bus between mem_access_unit and data memory.
// Signals:
//   bus_cyc_o, bus_stb_o  cycle / strobe (unit -> memory)
//   bus_we_o              write enable
//   bus_sel_o[3:0]        byte-lane enables
//   bus_adr_o[31:0]       word-aligned address
//   bus_dat_o[31:0]       lane-replicated store data
//   bus_dat_i[31:0]       read data (memory -> unit)
//   bus_ack_i, bus_err_i  cycle termination (memory -> unit)
// Handshake: a cycle is open while cyc/stb are high; every unit-side signal is
// held stable until the memory terminates it with ack or err (err wins when
// both are high in the same cycle).
// Modports: master = access unit side, slave = memory side.
interface mem_access_unit_if;
   logic        bus_cyc_o;
   logic        bus_stb_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_adr_o;
   logic [31:0] bus_dat_o;
   logic [31:0] bus_dat_i;
   logic        bus_ack_i;
   logic        bus_err_i;

   modport master (
      output bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o,
      input  bus_dat_i, bus_ack_i, bus_err_i
   );

   modport slave (
      input  bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o,
      output bus_dat_i, bus_ack_i, bus_err_i
   );
endinterface

// File: rtl/mem_access_unit_store_align.sv
// store_align: combinational byte-lane and store-data alignment.
// Ports:
//   we        1=store, 0=load
//   funct3    RISC-V load/store funct3
//   addr_lsb  byte address bits [1:0]
//   wdata     store data, value in low bits
//   sel       byte-lane enables (loads always use all four lanes)
//   dat       store data replicated across lanes
//   misalign  access not naturally aligned for its size
// Build option: MEM_MISALIGN_TRAP_EN enables the misalign flag; without it
// the flag is tied low and misaligned accesses go to the bus as-is.
module store_align
   import riscv_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lsb,
   input  logic [31:0] wdata,
   output logic [3:0]  sel,
   output logic [31:0] dat,
   output logic        misalign
);

   always_comb begin
      sel      = 4'b1111;
      dat      = wdata;
      misalign = 1'b0;

      if (we) begin
         case (funct3)
            F3_SB:   sel = 4'b0001 << addr_lsb;
            F3_SH:   sel = 4'b0011 << {addr_lsb[1], 1'b0};
            default: sel = 4'b1111;
         endcase
      end

      case (funct3)
         F3_SB:   dat = {4{wdata[7:0]}};
         F3_SH:   dat = {2{wdata[15:0]}};
         default: dat = wdata;
      endcase

`ifdef MEM_MISALIGN_TRAP_EN
      // Size comes from funct3[1:0]: byte (x00), halfword (x01), and every
      // other encoding is handled as a word.
      case (funct3[1:0])
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = addr_lsb[0];
         default: misalign = |addr_lsb;
      endcase
`endif
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access sequencer between execute and the load
// unit. Takes one load/store request at a time, runs one classic bus cycle
// and returns the raw bus word plus addr[1:0]/funct3 for load extraction.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_i, we_i, funct3_i,
//   addr_i, wdata_i         request, sampled only while ready_o=1
//   ready_o                 idle; request accepted this cycle if req_i=1
//   done_o, err_o           one-cycle completion pulse and fault flag
//   rdata_o                 bus word captured on a successful load
//   addr_lsb_o, funct3_o    latched request fields for the load unit
//   state_o                 FSM state (debug)
//   bus                     memory bus, master side
// Build option: MEM_MISALIGN_TRAP_EN makes misaligned requests complete one
// cycle after acceptance with err_o=1 and no bus cycle.
module mem_access_unit
   import riscv_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [2:0]          funct3_i,
   input  logic [31:0]         addr_i,
   input  logic [31:0]         wdata_i,
   output logic                ready_o,
   output logic                done_o,
   output logic                err_o,
   output logic [31:0]         rdata_o,
   output logic [1:0]          addr_lsb_o,
   output logic [2:0]          funct3_o,
   output mau_state_t          state_o,
   mem_access_unit_if.master   bus
);

   mau_state_t  state_q, state_d;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        idle, in_access, accept, bus_done;
   logic        al_we;
   logic [2:0]  al_funct3;
   logic [1:0]  al_lsb;
   logic [31:0] al_wdata;
   logic [3:0]  al_sel;
   logic [31:0] al_dat;
   logic        misalign;

   assign idle      = (state_q == ST_IDLE);
   assign in_access = (state_q == ST_ACCESS);
   assign accept    = idle & req_i;
   assign bus_done  = bus.bus_ack_i | bus.bus_err_i;

   // The aligner looks at the live request while idle (to decide on a
   // misalign trap at acceptance) and at the latched request otherwise, so
   // bus outputs stay stable for the whole cycle.
   assign al_we     = idle ? we_i     : we_q;
   assign al_funct3 = idle ? funct3_i : funct3_q;
   assign al_lsb    = idle ? addr_i[1:0] : addr_q[1:0];
   assign al_wdata  = idle ? wdata_i  : wdata_q;

   store_align u_store_align (
      .we       (al_we),
      .funct3   (al_funct3),
      .addr_lsb (al_lsb),
      .wdata    (al_wdata),
      .sel      (al_sel),
      .dat      (al_dat),
      .misalign (misalign)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (req_i) state_d = misalign ? ST_RESP : ST_ACCESS;
         ST_ACCESS: if (bus_done) state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q     <= we_i;
            funct3_q <= funct3_i;
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            err_q    <= misalign;
         end
         if (in_access && bus_done) begin
            err_q <= bus.bus_err_i;
            // Error wins over a simultaneous ack: the word is discarded.
            if (!we_q && !bus.bus_err_i) rdata_q <= bus.bus_dat_i;
         end
      end
   end

   assign ready_o    = idle;
   assign done_o     = (state_q == ST_RESP);
   assign err_o      = done_o & err_q;
   assign rdata_o    = rdata_q;
   assign addr_lsb_o = addr_q[1:0];
   assign funct3_o   = funct3_q;
   assign state_o    = state_q;

   // Bus outputs are driven only inside ACCESS and are zero otherwise.
   assign bus.bus_cyc_o = in_access;
   assign bus.bus_stb_o = in_access;
   assign bus.bus_we_o  = in_access & we_q;
   assign bus.bus_sel_o = in_access ? al_sel : 4'b0000;
   assign bus.bus_adr_o = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
   assign bus.bus_dat_o = in_access ? al_dat : 32'd0;

endmodule
